cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
- Shares the single RAM port between the instruction cache (single-word fills) and the data cache (two-word block fills, writebacks and flushes).
- Sits between the caches' memory-side interfaces and the RAM model or controller.
- The data cache has priority. A data-cache block transfer (word offset 0 then offset 4) is atomic: the grant is locked until both words complete.
- A starvation counter guarantees forward progress for the instruction cache.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- STARVE_LIMIT, 4, consecutive data-cache block grants allowed while iREN is pending before the icache is forced a grant. 0 = strict data-cache priority.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  ADDR_W  icache word address.
- iwait  out  1  0 = iload valid this cycle.
- iload  out  DATA_W  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  ADDR_W  dcache word address; bit 2 = block word offset.
- dstore  in  DATA_W  dcache write data.
- dwait  out  1  0 = dcache access complete this cycle.
- dload  out  DATA_W  dcache read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramack  in  1  RAM access completes this cycle (single-cycle pulse per word).

Behaviour:
- Reset (asynchronous, RST=1):
  - State = IDLE, starve_cnt = 0.
  - ramREN = ramWEN = 0; ramaddr = ramstore = 0.
  - iwait = dwait = 1; iload = dload = 0.
- States:
  - IDLE: no RAM strobes; both waits = 1. Arbitrates on registered requests (grant takes effect the next cycle):
    - dreq = dREN|dWEN and not forced → DGNT.
    - else iREN → IGNT.
    - else stay IDLE.
    - forced = (STARVE_LIMIT != 0) && iREN && starve_cnt >= STARVE_LIMIT → IGNT even if dreq.
  - IGNT:
    - ramREN = 1, ramaddr = iaddr.
    - On ramack: iwait = 0, iload = ramload, starve_cnt ← 0, → IDLE.
    - If iREN drops before ack: → IDLE, strobes drop the next cycle. No stale data is forwarded.
  - DGNT:
    - ramREN = dREN & ~dWEN; ramWEN = dWEN. dWEN wins if both are high.
    - ramaddr = daddr, ramstore = dstore.
    - On ramack: dwait = 0, dload = ramload.
    - Ack with daddr[2]=0: stay DGNT (lock) for the second word. The cache advances its address in the same cycle.
    - Ack with daddr[2]=1: block done, → IDLE. If iREN=1, starve_cnt increments, saturating at STARVE_LIMIT.
    - If dREN|dWEN drops without ack: → IDLE, lock released.
- Waits: each is 0 only in the ack cycle for its granted requester; the non-granted requester always sees wait = 1.
- Data outputs: iload/dload = ramload when that requester is granted, else 0.
- Latency:
  - Minimum of 2 cycles per request (IDLE decision + grant cycle with immediate ack).
  - A back-to-back dcache block is 1 arbitration cycle + 2 ack cycles.
  - Every return to IDLE costs exactly one dead cycle. This is the fairness point.
- Simultaneous iREN and dreq in IDLE: DGNT unless forced.
- ramack seen in IDLE: ignored.
- starve_cnt holds when iREN=0 at block completion.

Optional Feature:
- Macro: MEMARB_PERF_EN.
- When defined, two extra output ports exist:
  - icnt  out  32  completed icache words.
  - dcnt  out  32  completed dcache words.
- Each counter increments on its requester's ack cycle, saturates at 32'hFFFFFFFF, and resets to 0.
- When not defined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset mid-DGNT: assert RST during the first word of a dcache block → same cycle ramREN=ramWEN=0, dwait=1; after release state is IDLE and starve_cnt=0.
- iREN only, iaddr=0x40, RAM acks 1 cycle after grant with 0xDEADBEEF → iwait=0 for exactly one cycle with iload=0xDEADBEEF; RAM strobes present only in the grant cycle.
- Simultaneous iREN and dREN (daddr 0x100 then 0x104) → ramaddr=0x100 then 0x104, dwait=0 twice; iREN stays blocked through both words and is granted after one IDLE cycle.
- Lock check: raise iREN between the dcache's word-0 ack and word-1 → ramaddr stays 0x104 for the dcache; no icache strobe until block done.
- Starvation: STARVE_LIMIT=2, dWEN held continuously with iREN held → after 2 dcache blocks the icache is granted; starve_cnt=0 after the icache ack; the dcache resumes next.
- Both dREN and dWEN high, daddr=0x3100, dstore=0x5 → ramWEN=1, ramREN=0, ramstore=0x5. With MEMARB_PERF_EN: dcnt increments by 1 per ack.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one RAM port between icache and dcache with dcache block lock and icache starvation guard
// Optional per-requester word counters (icnt/dcnt) when MEMARB_PERF_EN is defined.
module cache_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramack
`ifdef MEMARB_PERF_EN
  ,
  output logic [31:0]       icnt,
  output logic [31:0]       dcnt
`endif
);

  localparam int CW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  state_t        state, next_state;
  logic [CW-1:0] starve_cnt;
  logic          dreq, forced, i_ack, d_ack, blk_done;

  assign dreq     = dREN | dWEN;
  assign forced   = (STARVE_LIMIT != 0) && iREN && (starve_cnt >= LIMIT);
  assign i_ack    = (state == IGNT) && ramack;
  assign d_ack    = (state == DGNT) && ramack;
  assign blk_done = d_ack && daddr[2];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= next_state;
      if (i_ack)
        starve_cnt <= '0;
      else if (blk_done && iREN && (starve_cnt < LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Every grant returns through IDLE, giving the other requester a decision point.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (dreq && !forced) next_state = DGNT;
        else if (iREN)       next_state = IGNT;
      end
      IGNT: begin
        if (ramack || !iREN) next_state = IDLE;
      end
      DGNT: begin
        if (ramack)     next_state = daddr[2] ? IDLE : DGNT;
        else if (!dreq) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state)
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iwait   = ~ramack;
        iload   = ramload;
      end
      DGNT: begin
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~ramack;
        dload    = ramload;
      end
      default: ;
    endcase
  end

`ifdef MEMARB_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icnt <= '0;
      dcnt <= '0;
    end else begin
      if (i_ack && (icnt != 32'hFFFFFFFF)) icnt <= icnt + 32'd1;
      if (d_ack && (dcnt != 32'hFFFFFFFF)) dcnt <= dcnt + 32'd1;
    end
  end
`endif

endmodule
